// File: rtl/fft_reader_pkg.sv
// Shared constants and state types for the FFT result reader.
package fft_reader_pkg;
    localparam int unsigned DEF_LGSIZE = 12;
    localparam int unsigned DEF_OWIDTH = 19;

    typedef enum logic [1:0] {WR_WAIT, WR_FILL, WR_DROP} wr_state_t;
    typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_t;
endpackage

// File: rtl/fft_reader_bank_ram.sv
// Simple dual-port frame RAM with a registered read port; the address MSB selects the bank.
module fft_reader_bank_ram
    import fft_reader_pkg::*;
#(
    parameter int unsigned AW = DEF_LGSIZE + 1,
    parameter int unsigned DW = 2 * DEF_OWIDTH
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Read register only advances on i_re, so it doubles as the held output stage.
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/fft_result_reader.sv
// Captures sync-aligned FFT frames into a ping-pong buffer and replays them over valid/ready.
// Optional o_mag (|re|+|im|) output is enabled by defining FFT_READER_MAG_EN.
module fft_result_reader
    import fft_reader_pkg::*;
#(
    parameter int unsigned LGSIZE = DEF_LGSIZE,
    parameter int unsigned OWIDTH = DEF_OWIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clk_enable,
    input  logic                i_sync,
    input  logic [2*OWIDTH-1:0] i_result,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*OWIDTH-1:0] o_data,
    output logic [LGSIZE-1:0]   o_bin,
    output logic                o_last,
    output logic                o_overflow,
    output logic                o_resync
`ifdef FFT_READER_MAG_EN
    ,
    output logic [OWIDTH:0]     o_mag
`endif
);
`ifdef FFT_READER_MAG_EN
    localparam int unsigned DW = 3 * OWIDTH + 1;

    function automatic logic [OWIDTH:0] f_mag(input logic [2*OWIDTH-1:0] v);
        logic [OWIDTH-1:0] re, im, are, aim;
        re  = v[2*OWIDTH-1:OWIDTH];
        im  = v[OWIDTH-1:0];
        // Negating the most-negative value wraps to exactly 2^(OWIDTH-1) when read unsigned.
        are = re[OWIDTH-1] ? (~re + 1'b1) : re;
        aim = im[OWIDTH-1] ? (~im + 1'b1) : im;
        return {1'b0, are} + {1'b0, aim};
    endfunction
`else
    localparam int unsigned DW = 2 * OWIDTH;
`endif

    wr_state_t         r_wstate, w_wstate_nxt;
    logic [LGSIZE-1:0] r_waddr, w_waddr_nxt, w_wloc;
    logic              r_wbank, w_we, w_set_full, w_set_ovf, w_set_rsy, w_wbank_empty;
    bank_state_t       r_bank [2];
    logic              r_rbank, w_adv, w_release, w_rbank_sel, w_issue;
    logic [LGSIZE:0]   r_raddr, w_raddr_sel;
    logic [DW-1:0]     w_wdata, w_rdata;

    assign w_wbank_empty = (r_bank[r_wbank] == BANK_EMPTY);

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_waddr_nxt  = r_waddr;
        w_wloc       = r_waddr;
        w_we         = 1'b0;
        w_set_full   = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_rsy    = 1'b0;
        if (i_clk_enable) begin
            case (r_wstate)
                WR_WAIT, WR_DROP: begin
                    if (i_sync) begin
                        if (w_wbank_empty) begin
                            w_we         = 1'b1;
                            w_wloc       = '0;
                            w_waddr_nxt  = LGSIZE'(1);
                            w_wstate_nxt = WR_FILL;
                        end else begin
                            w_wstate_nxt = WR_DROP;
                            w_set_ovf    = 1'b1;
                        end
                    end
                end
                WR_FILL: begin
                    w_we = 1'b1;
                    if (i_sync) begin
                        w_wloc      = '0;
                        w_waddr_nxt = LGSIZE'(1);
                        w_set_rsy   = 1'b1;
                    end else if (r_waddr == '1) begin
                        w_set_full   = 1'b1;
                        w_waddr_nxt  = '0;
                        w_wstate_nxt = WR_WAIT;
                    end else begin
                        w_waddr_nxt = r_waddr + 1'b1;
                    end
                end
                default: w_wstate_nxt = WR_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wstate   <= WR_WAIT;
            r_waddr    <= '0;
            r_wbank    <= 1'b0;
            o_overflow <= 1'b0;
            o_resync   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_waddr  <= w_waddr_nxt;
            if (w_set_full)
                r_wbank <= ~r_wbank;
            if (w_set_ovf)
                o_overflow <= 1'b1;
            if (w_set_rsy)
                o_resync <= 1'b1;
        end
    end

    // Registered bank state: a release this cycle is not visible to the writer until next cycle.
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < 2; b++) begin
            if (i_reset)
                r_bank[b] <= BANK_EMPTY;
            else if (w_set_full && (r_wbank == 1'(b)))
                r_bank[b] <= BANK_FULL;
            else if (w_release && (r_rbank == 1'(b)))
                r_bank[b] <= BANK_EMPTY;
        end
    end

    // On the last handshake the next read comes from the other bank in the same cycle.
    assign w_adv       = !o_valid || i_ready;
    assign w_release   = o_valid && i_ready && o_last;
    assign w_rbank_sel = w_release ? ~r_rbank : r_rbank;
    assign w_raddr_sel = w_release ? '0 : r_raddr;
    assign w_issue     = w_adv && (r_bank[w_rbank_sel] == BANK_FULL) && !w_raddr_sel[LGSIZE];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_bin   <= '0;
            r_rbank <= 1'b0;
            r_raddr <= '0;
        end else begin
            if (w_issue) begin
                r_rbank <= w_rbank_sel;
                r_raddr <= w_raddr_sel + 1'b1;
            end else if (w_release) begin
                r_rbank <= ~r_rbank;
                r_raddr <= '0;
            end
            if (w_adv) begin
                o_valid <= w_issue;
                o_last  <= w_issue && (w_raddr_sel[LGSIZE-1:0] == '1);
                if (w_issue)
                    o_bin <= w_raddr_sel[LGSIZE-1:0];
            end
        end
    end

`ifdef FFT_READER_MAG_EN
    assign w_wdata = {f_mag(i_result), i_result};
    assign o_mag   = w_rdata[DW-1:2*OWIDTH];
`else
    assign w_wdata = i_result;
`endif
    assign o_data = w_rdata[2*OWIDTH-1:0];

    fft_reader_bank_ram #(
        .AW(LGSIZE + 1),
        .DW(DW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_waddr({r_wbank, w_wloc}),
        .i_wdata(w_wdata),
        .i_re   (w_issue),
        .i_raddr({w_rbank_sel, w_raddr_sel[LGSIZE-1:0]}),
        .o_rdata(w_rdata)
    );
endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: frame-level reference model pushes beats, a monitor pops them.
`timescale 1ns/1ps
module tb_fft_result_reader;
    localparam int LG = 12;
    localparam int OW = 19;
    localparam int N  = 1 << LG;
    localparam int MW = OW + 1;

    logic            clk = 1'b0;
    logic            i_reset, i_clk_enable, i_sync, i_ready;
    logic [2*OW-1:0] i_result;
    logic            o_valid, o_last, o_overflow, o_resync;
    logic [2*OW-1:0] o_data;
    logic [LG-1:0]   o_bin;
`ifdef FFT_READER_MAG_EN
    logic [OW:0]     o_mag;
`endif

    always #5 clk = ~clk;

    fft_result_reader #(.LGSIZE(LG), .OWIDTH(OW)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_clk_enable(i_clk_enable),
        .i_sync      (i_sync),
        .i_result    (i_result),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_bin       (o_bin),
        .o_last      (o_last),
        .o_overflow  (o_overflow),
        .o_resync    (o_resync)
`ifdef FFT_READER_MAG_EN
        ,
        .o_mag       (o_mag)
`endif
    );

    typedef struct {
        logic [LG-1:0]   bin;
        logic [2*OW-1:0] data;
        logic            last;
        logic [MW-1:0]   mag;
    } beat_t;

    beat_t           exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              n_frames_out = 0;

    // Reference model state: a frame being captured, and how many complete frames await delivery.
    logic [2*OW-1:0] m_buf [N];
    int              m_len = 0;
    bit              m_cap = 0;
    int              m_stored = 0;
    bit              m_ovf = 0, m_rsy = 0;

    function automatic logic [2*OW-1:0] pack(input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        return {r[OW-1:0], i[OW-1:0]};
    endfunction

    function automatic logic [2*OW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[2*OW-1:0];
    endfunction

    task automatic push_frame();
        for (int k = 0; k < N; k++) begin
            beat_t b;
            int re, im;
            re     = $signed(m_buf[k][2*OW-1:OW]);
            im     = $signed(m_buf[k][OW-1:0]);
            b.bin  = LG'(k);
            b.data = m_buf[k];
            b.last = (k == N - 1);
            b.mag  = MW'((re < 0 ? -re : re) + (im < 0 ? -im : im));
            exp_q.push_back(b);
        end
    endtask

    // Model decides what the coming clock edge does, using inputs that are stable until that edge.
    always @(negedge clk) begin
        if (i_reset) begin
            exp_q.delete();
            m_len = 0; m_cap = 0; m_stored = 0; m_ovf = 0; m_rsy = 0;
        end else begin
            if (i_clk_enable) begin
                if (i_sync) begin
                    if (m_cap) begin
                        m_rsy = 1;
                        m_buf[0] = i_result;
                        m_len = 1;
                    end else if (m_stored < 2) begin
                        m_cap = 1;
                        m_buf[0] = i_result;
                        m_len = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end else if (m_cap) begin
                    m_buf[m_len] = i_result;
                    m_len++;
                    if (m_len == N) begin
                        push_frame();
                        m_stored++;
                        m_cap = 0;
                    end
                end
            end
            if (o_valid && i_ready && o_last)
                m_stored--;
        end
    end

    logic            h_held = 0;
    logic [2*OW-1:0] h_data;
    logic [LG-1:0]   h_bin;
    logic            h_last;

    always @(negedge clk) begin
        beat_t e;
        if (i_reset) begin
            h_held = 0;
        end else begin
            if (h_held) begin
                n_checks++;
                if (!o_valid || o_data !== h_data || o_bin !== h_bin || o_last !== h_last) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b bin=%0d data=%h last=%0b, required bin=%0d data=%h last=%0b held",
                             o_valid, o_bin, o_data, o_last, h_bin, h_data, h_last);
                end
            end
            if (o_valid && i_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected beat bin=%0d data=%h, no beat expected", o_bin, o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_bin !== e.bin || o_data !== e.data || o_last !== e.last
`ifdef FFT_READER_MAG_EN
                        || o_mag !== e.mag
`endif
                       ) begin
                        n_fail++;
                        $display("FAIL beat: got bin=%0d data=%h last=%0b, required bin=%0d data=%h last=%0b mag=%0d",
                                 o_bin, o_data, o_last, e.bin, e.data, e.last, e.mag);
                    end
                end
                if (o_last)
                    n_frames_out++;
            end
            h_held = o_valid && !i_ready;
            h_data = o_data;
            h_bin  = o_bin;
            h_last = o_last;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sync, input logic [2*OW-1:0] d, input bit gap);
        i_clk_enable = 1; i_sync = sync; i_result = d;
        tick();
        i_clk_enable = 0; i_sync = 0;
        if (gap) begin
            i_sync = 1'($urandom); i_result = rnd();
            tick();
            i_sync = 0;
        end
    endtask

    task automatic send_frame(input bit ramp, input bit gap);
        for (int k = 0; k < N; k++)
            send(k == 0, ramp ? pack(k, -k) : rnd(), gap);
    endtask

    task automatic check_reset_state();
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_last",  64'(o_last),  64'(0));
        check("rst_bin",   64'(o_bin),   64'(0));
        check("rst_ovf",   64'(o_overflow), 64'(0));
        check("rst_rsy",   64'(o_resync),   64'(0));
    endtask

    task automatic do_reset();
        i_reset = 1;
        tick();
        i_reset = 0;
        check_reset_state();
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || o_valid) && cyc < 3 * N) begin
            tick();
            cyc++;
        end
        check("drain_done", 64'(exp_q.size() == 0 && !o_valid), 64'(1));
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf"}, 64'(o_overflow), 64'(m_ovf));
        check({tag, "_rsy"}, 64'(o_resync),   64'(m_rsy));
    endtask

    initial begin
        int frames0;
        i_reset = 0; i_clk_enable = 0; i_sync = 0; i_result = '0; i_ready = 1;
        tick();
        do_reset();

        // Ramp frame with full throughput; o_valid must rise exactly two cycles after the last write.
        send_frame(1, 0);
        check("lat_t1_valid", 64'(o_valid), 64'(0));
        tick();
        check("lat_t2_valid", 64'(o_valid), 64'(1));
        check("lat_t2_bin",   64'(o_bin),   64'(0));
        drain();
        check_flags("ramp");

        // Gapped enable with junk on disabled cycles.
        send_frame(1, 1);
        drain();
        check_flags("gap");

        // Back-pressure: three frames arrive while the consumer stalls.
        do_reset();
        frames0 = n_frames_out;
        fork
            begin
                i_ready = 0;
                repeat (5000) tick();
                i_ready = 1;
            end
            begin
                for (int f = 0; f < 3; f++)
                    send_frame(0, 0);
            end
        join
        drain();
        check("bp_frames", 64'(n_frames_out - frames0), 64'(2));
        check("bp_ovf", 64'(o_overflow), 64'(1));
        check("bp_rsy", 64'(o_resync),   64'(0));
        check_flags("bp");

        // Mid-frame sync at bin 100.
        do_reset();
        for (int k = 0; k < 100; k++)
            send(k == 0, pack(k, -k), 0);
        send_frame(0, 0);
        drain();
        check("mid_rsy", 64'(o_resync),   64'(1));
        check("mid_ovf", 64'(o_overflow), 64'(0));

        // Reset while frame 0 is being read and frame 1 is at bin 2000.
        do_reset();
        send_frame(0, 0);
        for (int k = 0; k < 2000; k++)
            send(k == 0, rnd(), 0);
        check("pre_rst_valid", 64'(o_valid), 64'(1));
        i_reset = 1; i_clk_enable = 1; i_sync = 0; i_result = rnd();
        tick();
        i_reset = 0; i_clk_enable = 0;
        check_reset_state();
        for (int k = 0; k < 50; k++)
            send(0, rnd(), 0);
        frames0 = n_frames_out;
        send_frame(0, 0);
        drain();
        check("post_rst_frames", 64'(n_frames_out - frames0), 64'(1));

`ifdef FFT_READER_MAG_EN
        send(1, pack(-3, 5), 0);
        send(0, pack(-(1 << 18), 0), 0);
        for (int k = 2; k < N; k++)
            send(0, rnd(), 0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Sink for the streamed FFT output: one complex bin per enabled clock, with a sync flag on bin 0 of each frame.
- Aligns to the sync flag and captures each 2^LGSIZE-bin frame into a ping-pong (two-bank) buffer.
- Replays each captured frame to a downstream consumer over a valid/ready handshake, with bin index and last flag.
- Sits directly after fftmain's o_result/o_sync; decouples the fixed-rate FFT stream from a back-pressuring consumer.

Parameters:
- LGSIZE, 12, log2 of the frame length (4096 bins).
- OWIDTH, 19, width of each real/imag component; real in the upper half.

Ports:
- i_clk  in  1  clock; all logic synchronous to it.
- i_reset  in  1  synchronous reset, active high.
- i_clk_enable  in  1  qualifies i_result/i_sync; one sample accepted per enabled clock.
- i_sync  in  1  high with bin 0 of a frame.
- i_result  in  2*OWIDTH  complex bin {re, im}, two's complement.
- o_valid  out  1  o_data/o_bin/o_last hold a valid bin.
- i_ready  in  1  consumer accepts when o_valid && i_ready.
- o_data  out  2*OWIDTH  bin value.
- o_bin  out  LGSIZE  bin index 0..2^LGSIZE-1.
- o_last  out  1  high with bin 2^LGSIZE-1.
- o_overflow  out  1  sticky; a frame was dropped because no bank was free.
- o_resync  out  1  sticky; i_sync seen mid-frame.

Behaviour:
- Reset values: o_valid=0, o_last=0, o_bin=0, o_overflow=0, o_resync=0, both banks EMPTY, writer in WAIT, write bank=0, read bank=0. o_data is don't-care.
- Input is sampled only when i_clk_enable=1. Nothing is captured while i_clk_enable=0.
- Writer FSM:
  - WAIT: on enabled i_sync, write i_result to address 0 of the write bank. Set waddr=1. Go to FILL, or to DROP if the write bank is not EMPTY.
  - FILL: each enabled sample writes at waddr; waddr increments.
  - FILL, sample at waddr=2^LGSIZE-1: mark the bank FULL next cycle, toggle the write bank, go to WAIT.
  - DROP: discard samples until the next enabled i_sync. On entry set o_overflow. Re-evaluate bank availability at that sync, as in WAIT.
- Mid-frame sync: enabled i_sync while in FILL with waddr!=0:
  - set o_resync;
  - restart the frame in the same bank at address 0 (the sample is written to address 0, waddr=1);
  - discard the partial frame.
- Reader:
  - Memory read latency is 1 cycle. The output is registered and prefetched so that o_valid can stay high on consecutive cycles while i_ready=1 (full throughput).
  - When the read bank is FULL, issue reads for raddr=0..2^LGSIZE-1.
  - o_data/o_bin/o_last hold stable while o_valid && !i_ready.
  - On the handshake of the o_last beat: mark the read bank EMPTY (visible the next cycle), toggle the read bank, and resume immediately if the other bank is FULL.
- Latency: if the last bin is written in cycle t, the bank is FULL at t+1 and o_valid rises no earlier than t+2 (empty reader).
- Simultaneous events:
  - A bank release by the reader and a writer availability check at a sync in the same cycle: the writer sees the bank as busy. The frame is dropped; this is deterministic.
  - i_ready with o_valid=0 is ignored.
- Reset mid-operation: all frames in flight are abandoned. Sticky flags clear. The writer waits for the next enabled i_sync.
- Sticky flags clear only on reset.

Optional Feature:
- Macro FFT_READER_MAG_EN.
- When defined:
  - adds output o_mag, width OWIDTH+1, equal to |re|+|im| of o_data;
  - o_mag is registered alongside o_data with the same validity and hold rules;
  - abs of the most-negative value saturates to 2^(OWIDTH-1).
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package fft_reader_pkg holds:
  - constants for the default LGSIZE/OWIDTH;
  - a typedef for writer state {WAIT, FILL, DROP};
  - a typedef for bank state {EMPTY, FULL}.
- One sub-module: fft_reader_bank_ram, a simple dual-port RAM with 1-cycle registered read, sized 2^(LGSIZE+1) x 2*OWIDTH. The bank select is the MSB of the address.

Test Plan:
- Ramp frame, always ready: i_clk_enable=1, i_sync on bin 0, re=k and im=-k for bin k → 4096 beats with o_bin=k, o_data={k,-k} and o_last on k=4095. First o_valid occurs 2 cycles after bin 4095 is written.
- Gapped enable: i_clk_enable toggling 1/0 with the same ramp → identical output; no sample is captured on disabled cycles.
- Back-pressure: i_ready=0 for 5000 cycles while 3 frames stream in → frames 1 and 2 are delivered intact and frame 3 is dropped; o_overflow=1 and o_resync=0.
- Mid-frame sync: i_sync asserted again at bin 100 → o_resync=1; the delivered frame starts from that sample at o_bin=0; the partial frame is never output.
- Reset at bin 2000 of frame 1 while frame 0 is being read → all outputs return to reset values the next cycle; the next synced frame is delivered from bin 0.
- With FFT_READER_MAG_EN, bin re=-3, im=5 → o_mag=8; re=-2^18, im=0 → o_mag=2^18.
